// File: rtl/pq_cmd_issuer.sv
// Command front end for a register_tree priority queue: checks full/empty, pulses the queue strobes once, waits out the settle gap, then answers.
// Latency: accept to response is GAP+2 cycles when a strobe is issued and 1 cycle for rejects and peeks; a stalled response holds the block and keeps o_cmd_ready low.
module pq_cmd_issuer #(
   parameter int DATA_WIDTH = 16,
   parameter int QUEUE_SIZE = 15,
   parameter int ENQ_GAP    = $clog2(QUEUE_SIZE),
   parameter int DEQ_GAP    = 2,
   parameter int REP_GAP    = 2
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [1:0]            i_cmd_op,
   input  logic [DATA_WIDTH-1:0] i_cmd_data,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic [1:0]            o_rsp_status,
   output logic                  o_pq_wrt,
   output logic                  o_pq_read,
   output logic [DATA_WIDTH-1:0] o_pq_data,
   input  logic                  i_pq_full,
   input  logic                  i_pq_empty,
   input  logic [DATA_WIDTH-1:0] i_pq_data,
   output logic                  o_busy
);

   localparam int MAX_GAP = (ENQ_GAP > DEQ_GAP) ? ((ENQ_GAP > REP_GAP) ? ENQ_GAP : REP_GAP)
                                                : ((DEQ_GAP > REP_GAP) ? DEQ_GAP : REP_GAP);
   localparam int CNT_W   = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

   localparam logic [1:0] STS_OK    = 2'd0;
   localparam logic [1:0] STS_FULL  = 2'd1;
   localparam logic [1:0] STS_EMPTY = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_SETTLE,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_ENQ,
      OP_DEQ,
      OP_REP,
      OP_PEEK
   } op_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] dat;
      logic [1:0]            sts;
   } rsp_t;

   state_t                state_q, state_d;
   op_t                   op_q, op_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      gap_sel;
   rsp_t                  rsp_q, rsp_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic                  cmd_rdy_q, cmd_rdy_d;
   logic                  busy_q, busy_d;
   logic                  wrt_q, wrt_d;
   logic                  read_q, read_d;
   logic [DATA_WIDTH-1:0] pq_dat_q, pq_dat_d;

   always_comb begin
      case (op_q)
         OP_ENQ:  gap_sel = CNT_W'(ENQ_GAP);
         OP_REP:  gap_sel = CNT_W'(REP_GAP);
         default: gap_sel = CNT_W'(DEQ_GAP);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      rsp_d     = rsp_q;
      rsp_vld_d = rsp_vld_q;
      wrt_d     = 1'b0;
      read_d    = 1'b0;
      pq_dat_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid && cmd_rdy_q) begin
               op_d = op_t'(i_cmd_op);
               case (op_t'(i_cmd_op))
                  OP_ENQ: begin
                     if (i_pq_full) begin
                        state_d   = ST_RESP;
                        rsp_vld_d = 1'b1;
                        rsp_d     = '{dat: i_pq_data, sts: STS_FULL};
                     end else begin
                        state_d  = ST_ISSUE;
                        wrt_d    = 1'b1;
                        pq_dat_d = i_cmd_data;
                     end
                  end
                  OP_DEQ: begin
                     if (i_pq_empty) begin
                        state_d   = ST_RESP;
                        rsp_vld_d = 1'b1;
                        rsp_d     = '{dat: '0, sts: STS_EMPTY};
                     end else begin
                        state_d = ST_ISSUE;
                        read_d  = 1'b1;
                     end
                  end
                  // Replace on an empty queue degenerates to an insert inside the tree.
                  OP_REP: begin
                     state_d  = ST_ISSUE;
                     wrt_d    = 1'b1;
                     read_d   = 1'b1;
                     pq_dat_d = i_cmd_data;
                  end
                  default: begin
                     state_d   = ST_RESP;
                     rsp_vld_d = 1'b1;
                     if (i_pq_empty) rsp_d = '{dat: '0, sts: STS_EMPTY};
                     else            rsp_d = '{dat: i_pq_data, sts: STS_OK};
                  end
               endcase
            end
         end
         ST_ISSUE: begin
            // The strobe is in flight, so i_pq_data is still the pre-op top here.
            cnt_d     = gap_sel;
            rsp_d.sts = STS_OK;
            if (op_q != OP_ENQ || gap_sel == '0) rsp_d.dat = i_pq_data;
            if (gap_sel == '0) begin
               state_d   = ST_RESP;
               rsp_vld_d = 1'b1;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d   = ST_RESP;
               rsp_vld_d = 1'b1;
               if (op_q == OP_ENQ) rsp_d.dat = i_pq_data;
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d   = ST_IDLE;
               rsp_vld_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_rdy_d = (state_d == ST_IDLE);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_ENQ;
         cnt_q     <= '0;
         rsp_q     <= '0;
         rsp_vld_q <= 1'b0;
         cmd_rdy_q <= 1'b0;
         busy_q    <= 1'b0;
         wrt_q     <= 1'b0;
         read_q    <= 1'b0;
         pq_dat_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         rsp_q     <= rsp_d;
         rsp_vld_q <= rsp_vld_d;
         cmd_rdy_q <= cmd_rdy_d;
         busy_q    <= busy_d;
         wrt_q     <= wrt_d;
         read_q    <= read_d;
         pq_dat_q  <= pq_dat_d;
      end
   end

   assign o_cmd_ready  = cmd_rdy_q;
   assign o_rsp_valid  = rsp_vld_q;
   assign o_rsp_data   = rsp_q.dat;
   assign o_rsp_status = rsp_q.sts;
   assign o_pq_wrt     = wrt_q;
   assign o_pq_read    = read_q;
   assign o_pq_data    = pq_dat_q;
   assign o_busy       = busy_q;

endmodule
